board_input_debounce: RTL

BOARD_INPUT_DEBOUNCE -- requirements
Module: board_input_debounce

---
 rtl/board_input_debounce.sv | 86 ++++++++
 1 files changed

// File: rtl/board_input_debounce.sv
// Per-bit 2-flop synchronizer and counting debouncer for board KEY/SW pins,
// with optional sticky edge capture and interrupt (macro BOARD_INPUT_IRQ_EN).
module board_input_debounce #(
  parameter int             W               = 22,
  parameter int             DEBOUNCE_CYCLES = 500000,
  parameter logic [W-1:0]   INIT_VAL        = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] raw_in,
  output logic [W-1:0] clean_out,
  output logic [W-1:0] edge_flags,
  input  logic         clear_strobe,
  input  logic [W-1:0] clear_mask,
  input  logic [W-1:0] irq_mask,
  output logic         irq
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  // The toggle fires on the edge the count would reach DEBOUNCE_CYCLES,
  // so the register itself never holds more than DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0] w_toggle;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      logic          r_meta;
      logic          r_sync;
      logic          r_clean;
      logic [CW-1:0] r_cnt;
      logic          w_differ;

      assign w_differ     = (r_sync != r_clean);
      assign w_toggle[gi] = w_differ && (r_cnt == CNT_LAST);
      assign clean_out[gi] = r_clean;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_meta  <= INIT_VAL[gi];
          r_sync  <= INIT_VAL[gi];
          r_clean <= INIT_VAL[gi];
          r_cnt   <= '0;
        end else begin
          r_meta <= raw_in[gi];
          r_sync <= r_meta;
          if (!w_differ) begin
            r_cnt <= '0;
          end else if (w_toggle[gi]) begin
            r_cnt   <= '0;
            r_clean <= ~r_clean;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  endgenerate

`ifdef BOARD_INPUT_IRQ_EN
  logic [W-1:0] r_flags;
  logic [W-1:0] w_clear;

  assign w_clear = clear_strobe ? clear_mask : '0;

  // A toggle on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= '0;
    end else begin
      r_flags <= (r_flags & ~w_clear) | w_toggle;
    end
  end

  assign edge_flags = r_flags;
  assign irq        = |(r_flags & irq_mask);
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^{clear_strobe, clear_mask, irq_mask};
  assign edge_flags   = '0;
  assign irq          = 1'b0;
`endif

endmodule
